// File: rtl/skid_buffer_pkg.sv
// Shared types for the two-entry skid buffer register slice.
package skid_buffer_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_TWO   = 2'b10
  } skid_state_e;

endpackage

// File: rtl/skid_buffer_if.sv
// Upstream/downstream handshake bundle for skid_buffer.
// A word moves across either side at a posedge where valid and ready are both 1;
// the sender holds its data stable while valid=1 and ready=0 only if it wants
// that word delivered, and ready never depends combinationally on valid.
interface skid_buffer_if #(
  parameter int WIDTH = 4
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_data_o;

  // slave: the skid buffer itself
  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  // master: the environment driving upstream and consuming downstream
  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/skid_buffer_entry.sv
// One storage word with load enable and clear enable; load wins over clear.
module skid_buffer_entry #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (clear) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry ready/valid register slice with fully registered in_ready_o.
// Build option: SKID_BUFFER_CLEAR_EN zeroes each entry when it empties.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  skid_buffer_if.slave bus,
  output skid_state_e fsm_state
);

`ifdef SKID_BUFFER_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  skid_state_e      state;
  skid_state_e      next_state;
  logic             in_xfer;
  logic             out_xfer;
  logic             main_load;
  logic             main_sel_skid;
  logic             main_clear;
  logic             skid_load;
  logic             skid_clear;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign in_xfer  = bus.in_valid_i && bus.in_ready_o;
  assign out_xfer = bus.out_valid_o && bus.out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SKID_EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      SKID_EMPTY: if (in_xfer) next_state = SKID_ONE;
      SKID_ONE: begin
        if (in_xfer && !out_xfer) next_state = SKID_TWO;
        else if (!in_xfer && out_xfer) next_state = SKID_EMPTY;
      end
      SKID_TWO: if (out_xfer) next_state = SKID_ONE;
      default: next_state = SKID_EMPTY;
    endcase
  end

  always_comb begin
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    main_clear    = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    unique case (state)
      SKID_EMPTY: main_load = in_xfer;
      SKID_ONE: begin
        main_load  = in_xfer && out_xfer;
        skid_load  = in_xfer && !out_xfer;
        main_clear = CLEAR_EN && out_xfer && !in_xfer;
      end
      SKID_TWO: begin
        // in_ready_o is low here, so only the downstream side can move
        main_load     = out_xfer;
        main_sel_skid = 1'b1;
        skid_clear    = CLEAR_EN && out_xfer;
      end
      default: ;
    endcase
  end

  // Ready is a flop fed from next_state, breaking the out_ready_i -> in_ready_o path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.in_ready_o <= 1'b0;
    end else begin
      bus.in_ready_o <= (next_state != SKID_TWO);
    end
  end

  assign main_d = main_sel_skid ? skid_q : bus.in_data_i;

  skid_buffer_entry #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .q     (main_q)
  );

  skid_buffer_entry #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (bus.in_data_i),
    .q     (skid_q)
  );

  assign bus.out_valid_o = (state != SKID_EMPTY);
  assign bus.out_data_o  = main_q;
  assign fsm_state       = state;

endmodule
